// File: rtl/rot_sweep_ctrl.sv
// rot_sweep_ctrl: drives a 16-bit rotator's a/amt/lr inputs through a timed
// rotation sweep (amt 0..15), optionally repeating in the opposite direction.
module rot_sweep_ctrl #(
  parameter int unsigned DVSR = 25_000_000  // clock cycles per rotation step, >= 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] din,
  input  logic        dir,
  input  logic        bounce,
  output logic [15:0] a,
  output logic [3:0]  amt,
  output logic        lr,
  output logic        busy,
  output logic        done
);

  // Counter must be at least one bit wide even when DVSR == 1.
  localparam int unsigned CW = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam logic [CW-1:0] CntMax = CW'(DVSR - 1);

  typedef enum logic [0:0] {StIdle, StSweep} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          bounce_q;
  logic          rev_q;    // set once the return leg of a bounce sweep has begun
  logic          tick;

  assign tick = (cnt_q == CntMax);

  // Sweep FSM, prescaler and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bounce_q <= 1'b0;
      rev_q    <= 1'b0;
      a        <= 16'h0000;
      amt      <= 4'd0;
      lr       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // stop wins over a simultaneous start
          if (start && !stop) begin
            a        <= din;
            lr       <= dir;
            amt      <= 4'd0;
            cnt_q    <= '0;
            rev_q    <= 1'b0;
            bounce_q <= bounce;
            busy     <= 1'b1;
            state_q  <= StSweep;
          end
        end
        StSweep: begin
          if (stop) begin
            // Abort: a/amt/lr hold so the display freezes where it was.
            cnt_q   <= '0;
            busy    <= 1'b0;
            state_q <= StIdle;
          end else if (tick) begin
            cnt_q <= '0;
            if (amt != 4'd15) begin
              amt <= amt + 4'd1;
            end else if (bounce_q && !rev_q) begin
              lr    <= ~lr;
              amt   <= 4'd0;
              rev_q <= 1'b1;
            end else begin
              busy    <= 1'b0;
              done    <= 1'b1;
              state_q <= StIdle;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rot_sweep_ctrl.sv
// Self-checking bench for rot_sweep_ctrl: table of sweep checkpoints (DVSR=4)
// plus directed sequences for reset, abort, ignored inputs and DVSR=1.
module tb_rot_sweep_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] din = 16'h0000;
  logic        dir = 1'b0;
  logic        bounce = 1'b0;

  logic [15:0] a4, a1;
  logic [3:0]  amt4, amt1;
  logic        lr4, lr1, busy4, busy1, done4, done1;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rot_sweep_ctrl #(.DVSR(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .din(din), .dir(dir),
    .bounce(bounce), .a(a4), .amt(amt4), .lr(lr4), .busy(busy4), .done(done4)
  );

  rot_sweep_ctrl #(.DVSR(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .din(din), .dir(dir),
    .bounce(bounce), .a(a1), .amt(amt1), .lr(lr1), .busy(busy1), .done(done1)
  );

  typedef struct {
    logic [15:0] din;
    logic        dir;
    logic        bounce;
    int          t;      // edges after the start-accept edge
    logic [15:0] a;
    logic [3:0]  amt;
    logic        lr;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Present start for one edge, leave sampling at edge k + 1 time unit.
  task automatic launch(input logic [15:0] d, input logic dr, input logic b);
    @(negedge clk);
    din    = d;
    dir    = dr;
    bounce = b;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [15:0] d, input logic dr, input logic b, input int t,
                     input logic [15:0] ea, input logic [3:0] eamt, input logic elr,
                     input logic ebusy, input logic edone);
    vec_t v;
    v.din = d; v.dir = dr; v.bounce = b; v.t = t;
    v.a = ea; v.amt = eamt; v.lr = elr; v.busy = ebusy; v.done = edone;
    vecs.push_back(v);
  endtask

  initial begin
    int dcount;
    // Single right sweep, DVSR=4: amt=n after k+4n, done at k+64.
    add(16'h6000, 0, 0,   0, 16'h6000,  0, 0, 1, 0);
    add(16'h6000, 0, 0,   3, 16'h6000,  0, 0, 1, 0);
    add(16'h6000, 0, 0,   4, 16'h6000,  1, 0, 1, 0);
    add(16'h6000, 0, 0,  21, 16'h6000,  5, 0, 1, 0);
    add(16'h6000, 0, 0,  63, 16'h6000, 15, 0, 1, 0);
    add(16'h6000, 0, 0,  64, 16'h6000, 15, 0, 0, 1);
    add(16'h6000, 0, 0,  65, 16'h6000, 15, 0, 0, 0);
    // Bounce sweep: reversal at k+64, done at k+128.
    add(16'h6000, 0, 1,  63, 16'h6000, 15, 0, 1, 0);
    add(16'h6000, 0, 1,  64, 16'h6000,  0, 1, 1, 0);
    add(16'h6000, 0, 1,  68, 16'h6000,  1, 1, 1, 0);
    add(16'h6000, 0, 1, 127, 16'h6000, 15, 1, 1, 0);
    add(16'h6000, 0, 1, 128, 16'h6000, 15, 1, 0, 1);
    add(16'h6000, 0, 1, 129, 16'h6000, 15, 1, 0, 0);
    // Left-first sweeps.
    add(16'hA5C3, 1, 0,   0, 16'hA5C3,  0, 1, 1, 0);
    add(16'hA5C3, 1, 0,  64, 16'hA5C3, 15, 1, 0, 1);
    add(16'hA5C3, 1, 1,  64, 16'hA5C3,  0, 0, 1, 0);
    add(16'hA5C3, 1, 1,  98, 16'hA5C3,  8, 0, 1, 0);

    // Reset state, checked after an asynchronous assert mid-cycle.
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("reset_a", a4, 16'h0000);
    check("reset_busy", busy4, 0);
    check("reset_done", done4, 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      do_reset();
      launch(vecs[i].din, vecs[i].dir, vecs[i].bounce);
      cycles(vecs[i].t);
      check($sformatf("vec%0d_a", i), a4, vecs[i].a);
      check($sformatf("vec%0d_amt", i), amt4, vecs[i].amt);
      check($sformatf("vec%0d_lr", i), lr4, vecs[i].lr);
      check($sformatf("vec%0d_busy", i), busy4, vecs[i].busy);
      check($sformatf("vec%0d_done", i), done4, vecs[i].done);
    end

    // Async reset mid-sweep clears everything without a clock edge.
    do_reset();
    launch(16'h6000, 1, 1);
    cycles(30);
    #2 reset = 1'b1;
    #1;
    check("async_a", a4, 16'h0000);
    check("async_amt", amt4, 0);
    check("async_lr", lr4, 0);
    check("async_busy", busy4, 0);
    check("async_done", done4, 0);
    @(negedge clk);
    reset = 1'b0;

    // Abort at k+20 (amt=5): idle next cycle, amt frozen, no done ever.
    do_reset();
    launch(16'h6000, 0, 0);
    cycles(20);
    check("abort_pre_amt", amt4, 5);
    stop = 1'b1;
    cycles(1);
    stop = 1'b0;
    check("abort_busy", busy4, 0);
    check("abort_amt", amt4, 5);
    check("abort_a", a4, 16'h6000);
    dcount = 0;
    for (int c = 0; c < 80; c++) begin
      cycles(1);
      if (done4 || busy4) dcount++;
    end
    check("abort_no_done", dcount, 0);
    check("abort_hold_amt", amt4, 5);
    launch(16'h6000, 0, 0);
    check("restart_amt", amt4, 0);
    check("restart_busy", busy4, 1);

    // Start/din/dir changes during a sweep are ignored.
    do_reset();
    launch(16'h6000, 0, 0);
    cycles(9);
    start = 1'b1;
    din   = 16'hFFFF;
    dir   = 1'b1;
    cycles(3);
    start = 1'b0;
    cycles(28);
    check("ign_a", a4, 16'h6000);
    check("ign_lr", lr4, 0);
    check("ign_amt", amt4, 10);
    cycles(23);
    check("ign_busy63", busy4, 1);
    cycles(1);
    check("ign_done64", done4, 1);
    check("ign_a64", a4, 16'h6000);

    // start+stop together in IDLE: stays idle.
    do_reset();
    @(negedge clk);
    din   = 16'h1234;
    start = 1'b1;
    stop  = 1'b1;
    cycles(2);
    check("ss_busy", busy4, 0);
    check("ss_a", a4, 16'h0000);
    start = 1'b0;
    stop  = 1'b0;

    // Back-to-back: start held through done is accepted on the next edge.
    do_reset();
    @(negedge clk);
    din    = 16'h6000;
    dir    = 1'b0;
    bounce = 1'b0;
    start  = 1'b1;
    cycles(65);
    check("b2b_done", done4, 1);
    cycles(1);
    check("b2b_busy", busy4, 1);
    check("b2b_amt", amt4, 0);
    check("b2b_done_low", done4, 0);
    start = 1'b0;

    // DVSR=1: amt advances every cycle, done at k+16.
    do_reset();
    launch(16'h0F0F, 1, 0);
    for (int t = 0; t < 16; t++) begin
      check($sformatf("d1_amt%0d", t), amt1, t);
      check($sformatf("d1_busy%0d", t), busy1, 1);
      check($sformatf("d1_done%0d", t), done1, 0);
      cycles(1);
    end
    check("d1_done", done1, 1);
    check("d1_busy_end", busy1, 0);
    check("d1_lr", lr1, 1);
    check("d1_a", a1, 16'h0F0F);
    cycles(1);
    check("d1_done_low", done1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
